// File: rtl/ui_input_arbiter.sv
// ---------------------------------------------------------------------------
// ui_input_arbiter
//
// Purpose:
//    Conditions the raw controller buttons and decides who receives them.
//    Conditioning is done per button: a two-flop synchroniser, a debounce
//    counter, and a registered rising-edge detector.
//    The button stream then goes either to the UI state machine or to the game
//    program. Control passes into and out of the game through drain states.
//    In a drain state the buttons must all be released before the new owner
//    sees anything, so a press from one owner cannot leak into the other.
//    Holding Start for a long time while in the game raises a one-cycle exit
//    request back to the UI.
//
// Ports:
//    clk          system clock, all flops on the rising edge
//    rst          synchronous active-low reset
//    en           1 = run; 0 = freeze debounce/hold counters and the FSM
//    buttons_raw  asynchronous button pins {Start,C,B,A,Right,Left,Down,Up}
//    ui_state     UI FSM state (1000 = game)
//    btn_level    debounced levels, always visible
//    ui_press     one-cycle press pulses for the UI FSM
//    game_level   debounced levels for the game
//    game_press   one-cycle press pulses for the game
//    game_owner   1 while the game owns the buttons
//    exit_req     one-cycle game-exit request to the UI FSM
// ---------------------------------------------------------------------------
module ui_input_arbiter #(
   parameter int NBTN            = 8,
   parameter int DEBOUNCE_CYCLES = 250000,
   parameter int HOLD_CYCLES     = 25000000,
   parameter int CNT_W           = 25
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            en,
   input  logic [NBTN-1:0] buttons_raw,
   input  logic [3:0]      ui_state,
   output logic [NBTN-1:0] btn_level,
   output logic [NBTN-1:0] ui_press,
   output logic [NBTN-1:0] game_level,
   output logic [NBTN-1:0] game_press,
   output logic            game_owner,
   output logic            exit_req
);

   localparam int               START     = NBTN - 1;
   localparam logic [3:0]       GAME_CODE = 4'b1000;
   localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

   typedef enum logic [1:0] {
      UI_OWN   = 2'd0,
      DRAIN_G  = 2'd1,
      GAME_OWN = 2'd2,
      DRAIN_U  = 2'd3
   } state_t;

   logic [NBTN-1:0]  sync_a;
   logic [NBTN-1:0]  sync_b;
   logic [NBTN-1:0]  stable;
   logic [NBTN-1:0]  stable_prev;
   logic [NBTN-1:0]  press;
   logic [CNT_W-1:0] deb_cnt [NBTN];
   logic [CNT_W-1:0] hold_cnt;
   logic [CNT_W-1:0] hold_next;
   state_t           state;
   state_t           next_state;

   // Two-flop synchroniser. It keeps running while en=0, so the levels are
   // already current when the block is enabled again.
   always_ff @(posedge clk) begin
      if (!rst) begin
         sync_a <= '0;
         sync_b <= '0;
      end else begin
         sync_a <= buttons_raw;
         sync_b <= sync_a;
      end
   end

   // Debounce. A button's counter grows only while its synchronised level
   // disagrees with the accepted level; any agreement restarts the count.
   // The new level is accepted on the edge where the counter is already at
   // its last value, which gives a pin-to-level latency of 2 + DEBOUNCE_CYCLES.
   always_ff @(posedge clk) begin
      if (!rst) begin
         stable <= '0;
         for (int i = 0; i < NBTN; i++) begin
            deb_cnt[i] <= '0;
         end
      end else if (en) begin
         for (int i = 0; i < NBTN; i++) begin
            if (sync_b[i] != stable[i]) begin
               if (deb_cnt[i] == DEB_LAST) begin
                  stable[i]  <= sync_b[i];
                  deb_cnt[i] <= '0;
               end else begin
                  deb_cnt[i] <= deb_cnt[i] + CNT_W'(1);
               end
            end else begin
               deb_cnt[i] <= '0;
            end
         end
      end
   end

   // Registered rising-edge detector. stable_prev follows stable even while
   // en=0. Because of that, a pulse that was pending when en fell dies out
   // instead of being replayed later.
   always_ff @(posedge clk) begin
      if (!rst) begin
         stable_prev <= '0;
         press       <= '0;
      end else begin
         stable_prev <= stable;
         press       <= stable & ~stable_prev;
      end
   end

   // The ownership state and the Start-hold counter advance only while enabled.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= UI_OWN;
         hold_cnt <= '0;
      end else if (en) begin
         state    <= next_state;
         hold_cnt <= hold_next;
      end
   end

   // Routing is decided by the current state. A pulse that lands in the same
   // cycle as a transition therefore goes to the owner from before the change.
   // When the hold counter expires in the same cycle that ui_state leaves
   // game, exit_req is still pulsed; both paths lead to DRAIN_U.
   always_comb begin
      next_state = state;
      hold_next  = '0;
      btn_level  = stable;
      ui_press   = '0;
      game_level = '0;
      game_press = '0;
      game_owner = 1'b0;
      exit_req   = 1'b0;

      case (state)
         UI_OWN: begin
            ui_press = press & {NBTN{en}};
            if (ui_state == GAME_CODE) begin
               next_state = DRAIN_G;
            end
         end

         DRAIN_G: begin
            if (ui_state != GAME_CODE) begin
               next_state = UI_OWN;
            end else if (stable == '0) begin
               next_state = GAME_OWN;
            end
         end

         GAME_OWN: begin
            game_level = stable;
            game_press = press & {NBTN{en}};
            game_owner = 1'b1;
            if (ui_state != GAME_CODE) begin
               next_state = DRAIN_U;
            end
            if (stable[START]) begin
               if (hold_cnt == HOLD_LAST) begin
                  exit_req   = en;
                  next_state = DRAIN_U;
               end else begin
                  hold_next = hold_cnt + CNT_W'(1);
               end
            end
         end

         DRAIN_U: begin
            if (stable == '0) begin
               next_state = UI_OWN;
            end
         end

         default: begin
            next_state = UI_OWN;
         end
      endcase
   end

endmodule

// File: tb/tb_ui_input_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ui_input_arbiter
//
// Purpose:
//    Self-checking bench for ui_input_arbiter with short debounce and hold
//    times. The bench first runs a sequence of directed steps, then a stretch
//    of randomised button activity. After every clock it compares each DUT
//    output against a behavioural model of the arbiter.
//
// Ports:
//    none (top-level bench)
// ---------------------------------------------------------------------------
module tb_ui_input_arbiter;

   localparam int NBTN = 8;
   localparam int DEB  = 4;
   localparam int HOLD = 8;
   localparam int CW   = 5;

   logic            clk = 1'b0;
   logic            rst;
   logic            en;
   logic [NBTN-1:0] buttons_raw;
   logic [3:0]      ui_state;
   logic [NBTN-1:0] btn_level;
   logic [NBTN-1:0] ui_press;
   logic [NBTN-1:0] game_level;
   logic [NBTN-1:0] game_press;
   logic            game_owner;
   logic            exit_req;

   int checks   = 0;
   int failures = 0;

   ui_input_arbiter #(
      .NBTN            (NBTN),
      .DEBOUNCE_CYCLES (DEB),
      .HOLD_CYCLES     (HOLD),
      .CNT_W           (CW)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .en          (en),
      .buttons_raw (buttons_raw),
      .ui_state    (ui_state),
      .btn_level   (btn_level),
      .ui_press    (ui_press),
      .game_level  (game_level),
      .game_press  (game_press),
      .game_owner  (game_owner),
      .exit_req    (exit_req)
   );

   always #5 clk = ~clk;

   // Behavioural model. Ownership is tracked as one of four modes:
   // the UI owns the buttons, we are waiting for a clear pad before the game
   // takes over, the game owns the buttons, or we are waiting for a clear pad
   // before the UI takes over.
   localparam int M_UI    = 0;
   localparam int M_WAITG = 1;
   localparam int M_GAME  = 2;
   localparam int M_WAITU = 3;

   logic [7:0] pin_hist [2];
   int         run_len [NBTN];
   logic [7:0] acc;
   logic [7:0] acc_prev;
   logic [7:0] pulse;
   int         mode;
   int         start_time;

   task automatic modelReset();
      pin_hist[0] = '0;
      pin_hist[1] = '0;
      for (int i = 0; i < NBTN; i++) run_len[i] = 0;
      acc        = '0;
      acc_prev   = '0;
      pulse      = '0;
      mode       = M_UI;
      start_time = 0;
   endtask

   // One clock edge of the model, computed from the inputs as they stood
   // just before the edge.
   task automatic modelEdge();
      logic [7:0] sync_now;
      logic [7:0] acc_new;
      int         mode_new;
      int         start_new;
      bit         expired;
      bit         in_game_ui;
      if (!rst) begin
         modelReset();
      end else begin
         sync_now   = pin_hist[1];
         acc_new    = acc;
         mode_new   = mode;
         start_new  = start_time;
         in_game_ui = (ui_state == 4'b1000);
         if (en) begin
            // A level is accepted once the synchronised pin has disagreed
            // with it for DEB consecutive enabled edges.
            for (int i = 0; i < NBTN; i++) begin
               if (sync_now[i] !== acc[i]) begin
                  run_len[i] = run_len[i] + 1;
                  if (run_len[i] == DEB) begin
                     acc_new[i] = sync_now[i];
                     run_len[i] = 0;
                  end
               end else begin
                  run_len[i] = 0;
               end
            end
            expired = (mode == M_GAME) && acc[7] && (start_time + 1 == HOLD);
            case (mode)
               M_UI:    if (in_game_ui) mode_new = M_WAITG;
               M_WAITG: if (!in_game_ui) mode_new = M_UI;
                        else if (acc == 8'h00) mode_new = M_GAME;
               M_GAME:  if (expired || !in_game_ui) mode_new = M_WAITU;
               default: if (acc == 8'h00) mode_new = M_UI;
            endcase
            if (mode == M_GAME && acc[7] && !expired) start_new = start_time + 1;
            else start_new = 0;
         end
         pulse       = acc & ~acc_prev;
         acc_prev    = acc;
         acc         = acc_new;
         mode        = mode_new;
         start_time  = start_new;
         pin_hist[1] = pin_hist[0];
         pin_hist[0] = buttons_raw;
      end
   endtask

   task automatic checkValue(input string tag, input logic [7:0] observed, input logic [7:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         failures++;
         $error("[TB] FAIL %s: observed %h expected %h at %0t", tag, observed, expected, $time);
      end
   endtask

   task automatic checkInt(input string tag, input int observed, input int expected);
      checks++;
      assert (observed == expected)
      else begin
         failures++;
         $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   task automatic checkOutput();
      logic [7:0] e_ui;
      logic [7:0] e_gl;
      logic [7:0] e_gp;
      logic       e_owner;
      logic       e_exit;
      e_owner = (mode == M_GAME);
      e_ui    = (en && mode == M_UI) ? pulse : 8'h00;
      e_gl    = e_owner ? acc : 8'h00;
      e_gp    = (en && e_owner) ? pulse : 8'h00;
      e_exit  = en && e_owner && acc[7] && (start_time + 1 == HOLD);
      checkValue("btn_level", btn_level, acc);
      checkValue("ui_press", ui_press, e_ui);
      checkValue("game_level", game_level, e_gl);
      checkValue("game_press", game_press, e_gp);
      checkValue("game_owner", {7'b0, game_owner}, {7'b0, e_owner});
      checkValue("exit_req", {7'b0, exit_req}, {7'b0, e_exit});
   endtask

   task automatic applyStimulus(input logic r, input logic e, input logic [3:0] us, input logic [7:0] raw);
      rst         = r;
      en          = e;
      ui_state    = us;
      buttons_raw = raw;
      @(posedge clk);
      modelEdge();
      #1;
      checkOutput();
   endtask

   initial begin
      int         first;
      int         cnt_a;
      int         cnt_b;
      logic [7:0] seg_pat;
      int         seg_left;
      logic [3:0] rnd_state;
      logic       rnd_en;
      logic       rnd_rst;
      logic [7:0] drive;

      modelReset();
      rst         = 1'b0;
      en          = 1'b1;
      ui_state    = 4'b0001;
      buttons_raw = '0;

      // Reset: every output should be zero.
      applyStimulus(1'b0, 1'b1, 4'b0001, 8'h00);
      applyStimulus(1'b0, 1'b1, 4'b0001, 8'h00);
      checkValue("reset_levels", btn_level, 8'h00);
      checkValue("reset_owner", {7'b0, game_owner}, 8'h00);

      // A held in UI: the level rises 6 cycles after the pin, with one pulse.
      first = 0;
      cnt_a = 0;
      for (int k = 1; k <= 20; k++) begin
         applyStimulus(1'b1, 1'b1, 4'b0001, 8'h10);
         if (first == 0 && btn_level[4]) first = k;
         if (ui_press == 8'h10) cnt_a++;
      end
      checkInt("a_latency", first, 6);
      checkInt("a_ui_pulses", cnt_a, 1);
      for (int k = 0; k < 10; k++) applyStimulus(1'b1, 1'b1, 4'b0001, 8'h00);

      // A toggling every 2 cycles never settles long enough to be accepted.
      cnt_a = 0;
      for (int k = 0; k < 20; k++) begin
         applyStimulus(1'b1, 1'b1, 4'b0001, ((k / 2) % 2 == 0) ? 8'h10 : 8'h00);
         if (btn_level != 8'h00 || ui_press != 8'h00) cnt_a++;
      end
      checkInt("toggle_quiet", cnt_a, 0);
      for (int k = 0; k < 6; k++) applyStimulus(1'b1, 1'b1, 4'b0001, 8'h00);

      // Enter the game while A is held. The game must not see A.
      for (int k = 0; k < 10; k++) applyStimulus(1'b1, 1'b1, 4'b0001, 8'h10);
      cnt_a = 0;
      for (int k = 0; k < 6; k++) begin
         applyStimulus(1'b1, 1'b1, 4'b1000, 8'h10);
         if (game_press != 8'h00 || game_owner) cnt_a++;
      end
      checkInt("drain_g_silent", cnt_a, 0);
      for (int k = 0; k < 12; k++) applyStimulus(1'b1, 1'b1, 4'b1000, 8'h00);
      checkValue("game_owner_on", {7'b0, game_owner}, 8'h01);

      // Pressing Up in the game pulses the game only.
      cnt_a = 0;
      cnt_b = 0;
      for (int k = 0; k < 10; k++) begin
         applyStimulus(1'b1, 1'b1, 4'b1000, 8'h01);
         if (game_press == 8'h01) cnt_a++;
         if (ui_press != 8'h00) cnt_b++;
      end
      checkInt("up_game_pulses", cnt_a, 1);
      checkInt("up_ui_pulses", cnt_b, 0);
      for (int k = 0; k < 10; k++) applyStimulus(1'b1, 1'b1, 4'b1000, 8'h00);

      // A long Start hold gives exactly one exit request.
      cnt_a = 0;
      for (int k = 0; k < 20; k++) begin
         applyStimulus(1'b1, 1'b1, 4'b1000, 8'h80);
         if (exit_req) cnt_a++;
      end
      checkInt("long_start_exits", cnt_a, 1);
      checkValue("exit_owner_off", {7'b0, game_owner}, 8'h00);
      cnt_b = 0;
      for (int k = 0; k < 12; k++) begin
         applyStimulus(1'b1, 1'b1, 4'b0001, 8'h00);
         if (ui_press != 8'h00) cnt_b++;
      end
      checkInt("start_no_ui_pulse", cnt_b, 0);

      // Two short Start holds: the hold counter clears in between.
      for (int k = 0; k < 4; k++) applyStimulus(1'b1, 1'b1, 4'b1000, 8'h00);
      checkValue("regame_owner", {7'b0, game_owner}, 8'h01);
      cnt_a = 0;
      for (int k = 0; k < 30; k++) begin
         applyStimulus(1'b1, 1'b1, 4'b1000, (k < 5 || (k >= 15 && k < 20)) ? 8'h80 : 8'h00);
         if (exit_req) cnt_a++;
      end
      checkInt("short_holds_no_exit", cnt_a, 0);
      checkValue("short_holds_owner", {7'b0, game_owner}, 8'h01);

      // Reset in the middle of a hold.
      for (int k = 0; k < 10; k++) applyStimulus(1'b1, 1'b1, 4'b1000, 8'h80);
      applyStimulus(1'b0, 1'b1, 4'b0001, 8'h80);
      checkValue("midhold_rst_level", btn_level, 8'h00);
      checkValue("midhold_rst_owner", {7'b0, game_owner}, 8'h00);
      checkValue("midhold_rst_exit", {7'b0, exit_req}, 8'h00);

      // Reset in the middle of a debounce.
      for (int k = 0; k < 3; k++) applyStimulus(1'b1, 1'b1, 4'b0001, 8'h10);
      applyStimulus(1'b0, 1'b1, 4'b0001, 8'h00);
      checkValue("middeb_rst_level", btn_level, 8'h00);
      for (int k = 0; k < 6; k++) applyStimulus(1'b1, 1'b1, 4'b0001, 8'h00);
      checkValue("middeb_after_level", btn_level, 8'h00);

      // Drop en while an A pulse is pending. The pulse must never appear.
      for (int k = 0; k < 6; k++) applyStimulus(1'b1, 1'b1, 4'b0001, 8'h10);
      checkValue("en_pre_level", btn_level, 8'h10);
      cnt_a = 0;
      for (int k = 0; k < 10; k++) begin
         applyStimulus(1'b1, 1'b0, 4'b0001, 8'h10);
         if (ui_press != 8'h00 || btn_level != 8'h10) cnt_a++;
      end
      for (int k = 0; k < 10; k++) begin
         applyStimulus(1'b1, 1'b1, 4'b0001, 8'h10);
         if (ui_press != 8'h00) cnt_a++;
      end
      checkInt("en_drop_no_pulse", cnt_a, 0);
      checkValue("en_drop_owner", {7'b0, game_owner}, 8'h00);
      for (int k = 0; k < 8; k++) applyStimulus(1'b1, 1'b1, 4'b0001, 8'h00);

      // Randomised stretch with segments of steady patterns, bounces,
      // enable dropouts, ownership requests and occasional resets.
      seg_pat   = '0;
      seg_left  = 0;
      rnd_state = 4'b0001;
      rnd_en    = 1'b1;
      for (int k = 0; k < 1000; k++) begin
         if (seg_left == 0) begin
            seg_left = int'($urandom_range(1, 30));
            seg_pat  = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 2) == 0) seg_pat = 8'h00;
         end
         seg_left--;
         drive = seg_pat;
         if ($urandom_range(0, 7) == 0) drive[$urandom_range(0, 7)] ^= 1'b1;
         if ($urandom_range(0, 39) == 0) begin
            case ($urandom_range(0, 3))
               0:       rnd_state = 4'b0001;
               1:       rnd_state = 4'b0010;
               default: rnd_state = 4'b1000;
            endcase
         end
         if ($urandom_range(0, 24) == 0) rnd_en = ~rnd_en;
         rnd_rst = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
         applyStimulus(rnd_rst, rnd_en, rnd_state, drive);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
